// File: rtl/kl_align.sv
// kl_align: KLink aligner between unaligned upstream requests and 64-bit
// aligned targets. It splits lane-crossing requests and merges reads to lane 0.
module kl_align #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] up_req_addr,
  input  logic        up_req_wen,
  input  logic [63:0] up_req_wdata,
  input  logic [7:0]  up_req_wmask,
  input  logic [2:0]  up_req_size,
  input  logic [4:0]  up_req_srcid,
  input  logic        up_req_valid,
  output logic        up_req_ready,

  output logic [63:0] up_resp_rdata,
  output logic        up_resp_ren,
  output logic [2:0]  up_resp_size,
  output logic [4:0]  up_resp_dstid,
  output logic        up_resp_valid,
  input  logic        up_resp_ready,

  output logic [31:0] dn_req_addr,
  output logic        dn_req_wen,
  output logic [63:0] dn_req_wdata,
  output logic [7:0]  dn_req_wmask,
  output logic [2:0]  dn_req_size,
  output logic [4:0]  dn_req_srcid,
  output logic        dn_req_valid,
  input  logic        dn_req_ready,

  input  logic [63:0] dn_resp_rdata,
  input  logic        dn_resp_ren,
  input  logic [2:0]  dn_resp_size,
  input  logic [4:0]  dn_resp_dstid,
  input  logic        dn_resp_valid,
  output logic        dn_resp_ready
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [2:0] off;
    logic [2:0] size;
    logic [4:0] srcid;
    logic       ren;
    logic       split;
  } tag_t;

  typedef enum logic {IDLE, SECOND} req_st_t;
  typedef enum logic {RIDLE, RMERGE} rsp_st_t;

  function automatic logic [1:0] clamp_sz(input logic [2:0] s);
    return s[2] ? 2'd3 : s[1:0];
  endfunction

  function automatic logic [7:0] byte_en(input logic [1:0] s);
    logic [7:0] be;
    unique case (s)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0f;
      default: be = 8'hff;
    endcase
    return be;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  req_st_t       req_st;
  rsp_st_t       rsp_st;
  logic [31:0]   hold_addr;
  logic [63:0]   hold_wdata;
  logic [7:0]    hold_wmask;
  logic [63:0]   merge_q;

  tag_t          tag_mem [OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] tag_cnt;
  logic          tag_full;
  logic          tag_nonempty;
  logic          tag_pop;
  tag_t          tag_head;
  tag_t          tag_new;

  logic [2:0]    req_off;
  logic [1:0]    req_sz;
  logic [7:0]    req_mask;
  logic [3:0]    req_end;
  logic          req_split;
  logic [5:0]    req_sh0;
  logic [5:0]    req_sh1;
  logic [2:0]    req_rem;
  logic          up_fire;

  logic [63:0]   rsp_lm;
  logic [5:0]    rsp_sh0;
  logic [5:0]    rsp_sh1;
  logic [63:0]   rsp_low;
  logic [63:0]   rsp_merged;
  logic          rsp_last;
  logic          rsp_fire;

  logic          unused_ok;

  assign unused_ok = ^{dn_resp_ren, dn_resp_size, dn_resp_dstid};

  assign req_off   = up_req_addr[2:0];
  assign req_sz    = clamp_sz(up_req_size);
  assign req_mask  = up_req_wmask & byte_en(req_sz);
  assign req_end   = {1'b0, req_off} + (4'd1 << req_sz);
  assign req_split = req_end > 4'd8;
  // 3'd0 - off is 8 - off for every offset that can split
  assign req_rem   = 3'd0 - req_off;
  assign req_sh0   = {req_off, 3'b000};
  assign req_sh1   = {req_rem, 3'b000};

  assign tag_full     = tag_cnt == CW'(OUTSTANDING);
  assign tag_nonempty = tag_cnt != '0;

  assign up_req_ready = rst & (req_st == IDLE)
                      & (!dn_req_valid | dn_req_ready)
                      & !tag_full;
  assign up_fire      = up_req_valid & up_req_ready;
  assign dn_req_size  = 3'd3;

  assign tag_new.off   = req_off;
  assign tag_new.size  = up_req_size;
  assign tag_new.srcid = up_req_srcid;
  assign tag_new.ren   = !up_req_wen;
  assign tag_new.split = req_split;
  assign tag_head      = tag_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_st       <= IDLE;
      dn_req_valid <= 1'b0;
      dn_req_addr  <= '0;
      dn_req_wen   <= 1'b0;
      dn_req_wdata <= '0;
      dn_req_wmask <= '0;
      dn_req_srcid <= '0;
      hold_addr    <= '0;
      hold_wdata   <= '0;
      hold_wmask   <= '0;
    end else begin
      unique case (req_st)
        IDLE: begin
          if (up_fire) begin
            dn_req_valid <= 1'b1;
            dn_req_addr  <= {up_req_addr[31:3], 3'b000};
            dn_req_wen   <= up_req_wen;
            dn_req_wdata <= up_req_wdata << req_sh0;
            dn_req_wmask <= req_mask << req_off;
            dn_req_srcid <= up_req_srcid;
            if (req_split) begin
              hold_addr  <= {up_req_addr[31:3], 3'b000} + 32'd8;
              hold_wdata <= up_req_wdata >> req_sh1;
              hold_wmask <= req_mask >> req_rem;
              req_st     <= SECOND;
            end
          end else if (dn_req_ready) begin
            dn_req_valid <= 1'b0;
          end
        end
        SECOND: begin
          if (dn_req_ready) begin
            dn_req_addr  <= hold_addr;
            dn_req_wdata <= hold_wdata;
            dn_req_wmask <= hold_wmask;
            req_st       <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      if (up_fire) begin
        tag_mem[wr_ptr] <= tag_new;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (tag_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({up_fire, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  assign dn_resp_ready = rst & tag_nonempty
                       & (!up_resp_valid | up_resp_ready);
  assign rsp_fire      = dn_resp_valid & dn_resp_ready;

  assign rsp_lm     = lane_mask(byte_en(clamp_sz(tag_head.size)));
  assign rsp_sh0    = {tag_head.off, 3'b000};
  assign rsp_sh1    = {3'd0 - tag_head.off, 3'b000};
  assign rsp_low    = dn_resp_rdata >> rsp_sh0;
  assign rsp_merged = merge_q | (dn_resp_rdata << rsp_sh1);
  assign rsp_last   = !tag_head.split | (rsp_st == RMERGE);
  assign tag_pop    = rsp_fire & rsp_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_st        <= RIDLE;
      merge_q       <= '0;
      up_resp_valid <= 1'b0;
      up_resp_rdata <= '0;
      up_resp_ren   <= 1'b0;
      up_resp_size  <= '0;
      up_resp_dstid <= '0;
    end else begin
      if (up_resp_ready) begin
        up_resp_valid <= 1'b0;
      end
      if (rsp_fire) begin
        unique case (rsp_st)
          RIDLE: begin
            if (tag_head.split) begin
              merge_q <= rsp_low;
              rsp_st  <= RMERGE;
            end else begin
              up_resp_valid <= 1'b1;
              up_resp_rdata <= rsp_low & rsp_lm;
              up_resp_ren   <= tag_head.ren;
              up_resp_size  <= tag_head.size;
              up_resp_dstid <= tag_head.srcid;
            end
          end
          RMERGE: begin
            up_resp_valid <= 1'b1;
            up_resp_rdata <= rsp_merged & rsp_lm;
            up_resp_ren   <= tag_head.ren;
            up_resp_size  <= tag_head.size;
            up_resp_dstid <= tag_head.srcid;
            merge_q       <= '0;
            rsp_st        <= RIDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kl_align.sv
// tb_kl_align: random traffic against a byte-level memory reference,
// plus directed boundary scenarios for kl_align.
module tb_kl_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] up_req_addr = '0;
  logic        up_req_wen = 1'b0;
  logic [63:0] up_req_wdata = '0;
  logic [7:0]  up_req_wmask = '0;
  logic [2:0]  up_req_size = '0;
  logic [4:0]  up_req_srcid = '0;
  logic        up_req_valid = 1'b0;
  logic        up_req_ready;
  logic [63:0] up_resp_rdata;
  logic        up_resp_ren;
  logic [2:0]  up_resp_size;
  logic [4:0]  up_resp_dstid;
  logic        up_resp_valid;
  logic        up_resp_ready = 1'b0;
  logic [31:0] dn_req_addr;
  logic        dn_req_wen;
  logic [63:0] dn_req_wdata;
  logic [7:0]  dn_req_wmask;
  logic [2:0]  dn_req_size;
  logic [4:0]  dn_req_srcid;
  logic        dn_req_valid;
  logic        dn_req_ready = 1'b0;
  logic [63:0] dn_resp_rdata = '0;
  logic        dn_resp_ren = 1'b0;
  logic [2:0]  dn_resp_size = '0;
  logic [4:0]  dn_resp_dstid = '0;
  logic        dn_resp_valid = 1'b0;
  logic        dn_resp_ready;

  always #5 clk = ~clk;

  kl_align #(.OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .up_req_addr(up_req_addr), .up_req_wen(up_req_wen),
    .up_req_wdata(up_req_wdata), .up_req_wmask(up_req_wmask),
    .up_req_size(up_req_size), .up_req_srcid(up_req_srcid),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
    .up_resp_rdata(up_resp_rdata), .up_resp_ren(up_resp_ren),
    .up_resp_size(up_resp_size), .up_resp_dstid(up_resp_dstid),
    .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready),
    .dn_req_addr(dn_req_addr), .dn_req_wen(dn_req_wen),
    .dn_req_wdata(dn_req_wdata), .dn_req_wmask(dn_req_wmask),
    .dn_req_size(dn_req_size), .dn_req_srcid(dn_req_srcid),
    .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
    .dn_resp_rdata(dn_resp_rdata), .dn_resp_ren(dn_resp_ren),
    .dn_resp_size(dn_resp_size), .dn_resp_dstid(dn_resp_dstid),
    .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  size;
    logic [4:0]  srcid;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic        wen;
    logic [4:0]  srcid;
  } beat_t;

  typedef struct {
    logic [63:0] rdata;
    logic        ren;
    logic [2:0]  size;
    logic [4:0]  dstid;
  } rsp_t;

  req_t        gen_q[$];
  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  logic [63:0] tgt_q[$];

  logic [63:0] tgt_mem [32];
  logic [7:0]  ref_mem [256];

  int checks = 0;
  int errors = 0;

  int unsigned p_req = 100, p_dn = 100, p_resp = 100, p_up = 100;
  bit up_acc, dn_acc, rsp_acc, up_out, hold_chk;
  logic [127:0] hold_val;
  int dn_beats = 0, resp_cnt = 0;
  logic [31:0] last_dn_addr;
  logic [7:0]  last_dn_wmask;
  logic [63:0] last_dn_wdata;
  logic [63:0] last_rdata;
  logic [4:0]  last_dstid;
  logic        last_ren;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync_mem();
    for (int w = 0; w < 32; w++)
      for (int k = 0; k < 8; k++)
        ref_mem[w*8 + k] = tgt_mem[w][k*8 +: 8];
  endtask

  // byte-level reference: each upstream byte i lives at address addr+i
  task automatic model_accept();
    beat_t b0, b1;
    rsp_t  e;
    int nb, off, lane;
    logic [7:0] a8;
    nb  = 1 << ((up_req_size > 3) ? 3 : int'(up_req_size));
    off = int'(up_req_addr[2:0]);
    b0.addr  = {up_req_addr[31:3], 3'b000};
    b1.addr  = b0.addr + 32'd8;
    b0.wmask = '0; b1.wmask = '0;
    b0.wdata = '0; b1.wdata = '0;
    b0.wen = up_req_wen; b1.wen = up_req_wen;
    b0.srcid = up_req_srcid; b1.srcid = up_req_srcid;
    e.rdata = '0;
    for (int i = 0; i < nb; i++) begin
      lane = (off + i) % 8;
      a8   = 8'(up_req_addr[7:0] + 8'(i));
      if (off + i >= 8) begin
        b1.wmask[lane] = up_req_wmask[i];
        b1.wdata[lane*8 +: 8] = up_req_wdata[i*8 +: 8];
      end else begin
        b0.wmask[lane] = up_req_wmask[i];
        b0.wdata[lane*8 +: 8] = up_req_wdata[i*8 +: 8];
      end
      e.rdata[i*8 +: 8] = ref_mem[a8];
      if (up_req_wen && up_req_wmask[i])
        ref_mem[a8] = up_req_wdata[i*8 +: 8];
    end
    beat_q.push_back(b0);
    if (off + nb > 8) beat_q.push_back(b1);
    e.ren = !up_req_wen;
    e.size = up_req_size;
    e.dstid = up_req_srcid;
    rsp_q.push_back(e);
  endtask

  function automatic logic [63:0] lanes(input logic [7:0] m);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = {8{m[k]}};
    return r;
  endfunction

  task automatic step();
    req_t  r;
    beat_t b;
    rsp_t  e;
    logic [63:0] lm;
    int w;
    @(negedge clk);
    if (!up_req_valid || up_acc) begin
      up_req_valid = 1'b0;
      if (gen_q.size() > 0 && $urandom_range(99) < p_req) begin
        r = gen_q.pop_front();
        up_req_addr = r.addr; up_req_wen = r.wen;
        up_req_wdata = r.wdata; up_req_wmask = r.wmask;
        up_req_size = r.size; up_req_srcid = r.srcid;
        up_req_valid = 1'b1;
      end
    end
    if (!dn_resp_valid || rsp_acc) begin
      dn_resp_valid = 1'b0;
      if (tgt_q.size() > 0 && $urandom_range(99) < p_resp) begin
        dn_resp_rdata = tgt_q[0];
        dn_resp_dstid = 5'($urandom);
        dn_resp_ren = 1'($urandom);
        dn_resp_size = 3'($urandom);
        dn_resp_valid = 1'b1;
      end
    end
    dn_req_ready  = $urandom_range(99) < p_dn;
    up_resp_ready = $urandom_range(99) < p_up;
    #1;
    if (hold_chk)
      check("dn_hold", {23'd0, dn_req_valid, dn_req_addr, dn_req_wmask,
                        dn_req_wdata}, hold_val);
    up_acc  = up_req_valid && up_req_ready;
    dn_acc  = dn_req_valid && dn_req_ready;
    rsp_acc = dn_resp_valid && dn_resp_ready;
    up_out  = up_resp_valid && up_resp_ready;
    hold_chk = dn_req_valid && !dn_req_ready;
    hold_val = {23'd0, dn_req_valid, dn_req_addr, dn_req_wmask, dn_req_wdata};
    if (up_acc) model_accept();
    if (rsp_acc) void'(tgt_q.pop_front());
    if (dn_acc) begin
      dn_beats++;
      last_dn_addr = dn_req_addr;
      last_dn_wmask = dn_req_wmask;
      last_dn_wdata = dn_req_wdata;
      check("dn_avail", 128'(beat_q.size() != 0), 128'(1));
      if (beat_q.size() != 0) begin
        b = beat_q.pop_front();
        lm = lanes(b.wmask);
        check("dn_addr", 128'(dn_req_addr), 128'(b.addr));
        check("dn_wmask", 128'(dn_req_wmask), 128'(b.wmask));
        check("dn_wdata", 128'(dn_req_wdata & lm), 128'(b.wdata & lm));
        check("dn_wen", 128'(dn_req_wen), 128'(b.wen));
        check("dn_srcid", 128'(dn_req_srcid), 128'(b.srcid));
        check("dn_size", 128'(dn_req_size), 128'(3));
      end
      w = int'(dn_req_addr[7:3]);
      if (dn_req_wen) begin
        for (int k = 0; k < 8; k++)
          if (dn_req_wmask[k]) tgt_mem[w][k*8 +: 8] = dn_req_wdata[k*8 +: 8];
        tgt_q.push_back({$urandom, $urandom});
      end else begin
        tgt_q.push_back(tgt_mem[w]);
      end
    end
    if (up_out) begin
      check("resp_avail", 128'(rsp_q.size() != 0), 128'(1));
      if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        resp_cnt++;
        last_rdata = up_resp_rdata;
        last_dstid = up_resp_dstid;
        last_ren = up_resp_ren;
        check("resp_ren", 128'(up_resp_ren), 128'(e.ren));
        check("resp_size", 128'(up_resp_size), 128'(e.size));
        check("resp_dstid", 128'(up_resp_dstid), 128'(e.dstid));
        if (e.ren) check("resp_rdata", 128'(up_resp_rdata), 128'(e.rdata));
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((gen_q.size() > 0 || beat_q.size() > 0 || rsp_q.size() > 0 ||
            (up_req_valid && !up_acc)) && n < budget) begin
      step();
      n++;
    end
    check("drain", 128'(gen_q.size() + beat_q.size() + rsp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    up_req_valid = 1'b0; dn_resp_valid = 1'b0;
    dn_req_ready = 1'b0; up_resp_ready = 1'b0;
    gen_q.delete(); beat_q.delete(); rsp_q.delete(); tgt_q.delete();
    up_acc = 0; dn_acc = 0; rsp_acc = 0; up_out = 0; hold_chk = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sync_mem();
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic wen,
                              input logic [63:0] d, input logic [7:0] m,
                              input logic [2:0] s, input logic [4:0] id);
    req_t r;
    r.addr = a; r.wen = wen; r.wdata = d;
    r.wmask = m; r.size = s; r.srcid = id;
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb, nr;
    bit seen;
    for (int w = 0; w < 32; w++) tgt_mem[w] = {$urandom, $urandom};
    sync_mem();
    #1 rst = 1'b0;
    #2;
    check("rst_dn_valid", 128'(dn_req_valid), 128'(0));
    check("rst_up_valid", 128'(up_resp_valid), 128'(0));
    check("rst_up_ready", 128'(up_req_ready), 128'(0));
    check("rst_dn_ready", 128'(dn_resp_ready), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_up_ready", 128'(up_req_ready), 128'(1));
    check("post_rst_dn_ready", 128'(dn_resp_ready), 128'(0));

    // aligned full write, then sub-word write into lane 3
    gen_q.push_back(mk(32'h1000, 1'b1, 64'h1122334455667788, 8'hff, 3'd3, 5'd1));
    drain(200);
    check("t1_addr", 128'(last_dn_addr), 128'(32'h1000));
    check("t1_wmask", 128'(last_dn_wmask), 128'(8'hff));
    check("t1_wdata", 128'(last_dn_wdata), 128'(64'h1122334455667788));
    check("t1_ren", 128'(last_ren), 128'(0));
    gen_q.push_back(mk(32'h1003, 1'b1, 64'hab, 8'hff, 3'd0, 5'd2));
    drain(200);
    check("t2_addr", 128'(last_dn_addr), 128'(32'h1000));
    check("t2_wmask", 128'(last_dn_wmask), 128'(8'h08));
    check("t2_wdata", 128'(last_dn_wdata), 128'(64'h00000000ab000000));

    // split read merging two target words
    tgt_mem[0] = 64'hbbaa000000000000;
    tgt_mem[1] = 64'h000000000000ddcc;
    sync_mem();
    nb = dn_beats;
    gen_q.push_back(mk(32'h2006, 1'b0, 64'h0, 8'hff, 3'd2, 5'd7));
    drain(200);
    check("t3_beats", 128'(dn_beats - nb), 128'(2));
    check("t3_rdata", 128'(last_rdata), 128'(64'h00000000ddccbbaa));
    check("t3_dstid", 128'(last_dstid), 128'(7));

    // tag FIFO full with no responses, then one response frees a slot
    for (int i = 0; i < 5; i++)
      gen_q.push_back(mk(32'h1000 + 32'(8*i), 1'b0, 64'h0, 8'hff, 3'd3, 5'(i)));
    p_resp = 0;
    repeat (20) step();
    check("t4_full_ready", 128'(up_req_ready), 128'(0));
    check("t4_pending", 128'(up_req_valid), 128'(1));
    p_resp = 100;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = rsp_acc;
    end
    check("t4_resp_seen", 128'(seen), 128'(1));
    p_resp = 0;
    step();
    check("t4_ready_back", 128'(up_req_ready), 128'(1));
    p_resp = 100;
    drain(200);

    // split write with a stalled target
    gen_q.push_back(mk(32'h1005, 1'b1, 64'h0102030405060708, 8'hff, 3'd3, 5'd9));
    gen_q.push_back(mk(32'h1040, 1'b1, 64'hcafe, 8'h03, 3'd1, 5'd10));
    p_dn = 0;
    step();
    check("t5_accept", 128'(up_acc), 128'(1));
    repeat (5) begin
      step();
      check("t5_no_accept", 128'(up_req_ready), 128'(0));
      check("t5_dn_valid", 128'(dn_req_valid), 128'(1));
    end
    p_dn = 100;
    drain(200);

    // randomized traffic in batches with varied backpressure
    for (int bt = 0; bt < 6; bt++) begin
      p_req  = $urandom_range(40, 100);
      p_dn   = $urandom_range(40, 100);
      p_resp = $urandom_range(40, 100);
      p_up   = $urandom_range(40, 100);
      for (int i = 0; i < 50; i++)
        gen_q.push_back(mk($urandom, 1'($urandom), {$urandom, $urandom},
                           8'($urandom), 3'($urandom_range(0, 7)), 5'($urandom)));
      drain(4000);
    end
    p_req = 100; p_dn = 100; p_resp = 100; p_up = 100;

    // asynchronous reset in the middle of split traffic
    gen_q.push_back(mk(32'h1006, 1'b0, 64'h0, 8'hff, 3'd2, 5'd3));
    gen_q.push_back(mk(32'h1027, 1'b1, 64'h55aa55aa, 8'hff, 3'd3, 5'd4));
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    check("t6_dn_valid", 128'(dn_req_valid), 128'(0));
    check("t6_up_valid", 128'(up_resp_valid), 128'(0));
    check("t6_up_ready", 128'(up_req_ready), 128'(0));
    check("t6_dn_ready", 128'(dn_resp_ready), 128'(0));
    do_reset();
    nr = resp_cnt;
    gen_q.push_back(mk(32'h1010, 1'b0, 64'h0, 8'hff, 3'd3, 5'd12));
    drain(200);
    check("t6_resp_count", 128'(resp_cnt - nr), 128'(1));
    check("t6_rdata", 128'(last_rdata), 128'(tgt_mem[2]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
